ifetch_byte16: RTL
==================

# ifetch_byte16

Instruction fetch stage for the FCPU. It sits directly downstream of the 2K x 8 dual-port block RAM and drives that RAM's read port (port A, write enable tied low). Each cycle it issues at most one byte address and assembles consecutive bytes into 16-bit little-endian instruction words. Those words pass through a 2-entry prefetch FIFO and are presented to the decoder on a valid/ready handshake, with a flush-and-redirect input for branches.

## Interface
- `ADDR_W`, default 11: byte address width; the PC wraps modulo 2^ADDR_W.
- `RESET_PC`, default 0: fetch address after reset. Must be even.

- `clk` in 1: single clock; the RAM shares it.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ram_addr` out ADDR_W: byte address to the RAM read port. Driven combinationally from the internal fetch address `faddr`.
- `ram_q` in 8: RAM read data. Valid in the cycle after the RAM samples `ram_addr`.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in ADDR_W: new fetch address. Bit 0 is ignored and forced to 0.
- `instr_valid` out 1: FIFO head valid.
- `instr` out 16: FIFO head word, formed as {byte at pc+1, byte at pc}.
- `instr_pc` out ADDR_W: byte address of the head word's low byte.
- `instr_ready` in 1: decoder accepts the head word.

## Operation
- Reset values:
  - `faddr` = RESET_PC, so `ram_addr` = RESET_PC.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
  - FIFO empty, `inflight` = 0, `have_lo` = 0.
- Issue:
  - At a rising edge where issue is allowed, the RAM samples `faddr`. On that edge, `faddr` increments by 1 (mod 2^ADDR_W), `inflight` is set to 1, and the issued address's bit 0 is recorded as `inflight_hi`.
- Issue rule:
  - `faddr[0]` = 1 (high byte): always allowed, because its slot was reserved by the low byte.
  - `faddr[0]` = 0 (low byte): allowed only if FIFO count + `pending` < 2, where `pending` = `have_lo` OR (`inflight` AND NOT `inflight_hi`).
- Capture: on an edge with `inflight` = 1:
  - Low byte: store `ram_q` in `lo_byte`, store its address in `lo_pc`, set `have_lo`.
  - High byte: push {`ram_q`, `lo_byte`} with `lo_pc` into the FIFO and clear `have_lo`.
- Pop: on an edge with `instr_valid` AND `instr_ready`, the head is removed. A push and a pop on the same edge are both performed; the count is unchanged.
- FIFO:
  - Depth 2, registered outputs.
  - `instr`/`instr_pc` hold their value while `instr_valid` = 1 and `instr_ready` = 0.
  - Overflow is impossible by the issue rule.
- Redirect has highest priority. On an edge with `redirect` = 1:
  - FIFO is emptied; `have_lo` and `inflight` are cleared.
  - `faddr` <= {redirect_pc[ADDR_W-1:1], 0}.
  - No issue is counted on that edge; the byte the RAM samples there is discarded. Any pop on that edge is discarded.
  - `instr_valid` = 0 in the following cycle.
- Redirect held for several cycles: the unit reloads every cycle and never issues.
- Wrap-around: a word at address 2^ADDR_W-2 takes its high byte from 2^ADDR_W-1; the next word is at address 0.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight RAM data is ignored.

## Timing
- Cold start:
  - The first edge after `rst_n` rises issues RESET_PC (edge E0).
  - Low byte captured at E1, high byte captured and pushed at E2.
  - `instr_valid` = 1 after E2.
- Redirect at edge R: first issue at R+1; `instr_valid` = 1 after R+3.
- Peak throughput: one word per 2 cycles, limited by the byte-wide RAM.
- With `instr_ready` held high, `instr_valid` toggles 1/0 in steady state.
- `instr_valid` depends only on registers; there is no combinational path from `instr_ready` to `instr_valid`.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds output port `stall_cnt` (out, 16 bits).
  - Reset value 0.
  - Increments by 1 on every edge where `instr_valid` = 0 and `redirect` = 0.
  - Saturates at 16'hFFFF.
- `IFETCH_PERF_EN` undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Cold start, RAM bytes 0..3 = 48,03,4C,03, `instr_ready` = 1:
  - `instr` = 16'h0348, `instr_pc` = 0 after E2.
  - `instr` = 16'h034C, `instr_pc` = 2 two cycles later.
- `instr_ready` = 0 for 10 cycles, then 1:
  - Exactly two words are buffered and `ram_addr` stops advancing at 4.
  - Words then drain as pc 0 then pc 2, with no loss or duplication.
- `redirect` = 1, `redirect_pc` = 11'h021 while the FIFO holds 2 words:
  - `instr_valid` = 0 the next cycle.
  - The next word has `instr_pc` = 11'h020, valid 3 edges after redirect.
- Redirect to 11'h7FE:
  - First word = {mem[7FF], mem[7FE]}.
  - Second word has `instr_pc` = 0.
- `rst_n` pulsed low while a low byte is in flight:
  - After release, the first word is from RESET_PC.
  - No stale byte appears.
  - With `IFETCH_PERF_EN`, `stall_cnt` = 0 after reset and counts exactly 3 cold-start cycles.

Source files
------------

// File: rtl/ifetch_byte16_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_byte16_if
// Brief    : Byte-RAM read port plus decoder valid/ready and redirect bundle.
// Revision : 1.0
// ============================================================================
interface ifetch_byte16_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output ram_addr,
    input  ram_q,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  ram_addr,
    output ram_q,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_byte16.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_byte16
// Brief    : Byte-serial instruction fetch into a 2-entry 16-bit word FIFO.
//            Optional IFETCH_PERF_EN adds a saturating stall counter port.
// Revision : 1.0
// ============================================================================
module ifetch_byte16 #(
  parameter int          ADDR_W   = 11,
  parameter int unsigned RESET_PC = 0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  ifetch_byte16_if.master  bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_faddr;
  logic              r_inflight;
  logic              r_inflight_hi;
  logic              r_have_lo;
  logic [7:0]        r_lo_byte;
  logic [ADDR_W-1:0] r_lo_pc;
  logic [1:0]        r_count;
  logic [15:0]       r_word0;
  logic [15:0]       r_word1;
  logic [ADDR_W-1:0] r_pc0;
  logic [ADDR_W-1:0] r_pc1;

  logic              w_pending;
  logic [2:0]        w_occupancy;
  logic              w_issue;
  logic              w_capture_lo;
  logic              w_push;
  logic              w_pop;
  logic [15:0]       w_new_word;

  // A word slot is reserved when its low byte issues, so the high byte never blocks.
  assign w_pending    = r_have_lo | (r_inflight & ~r_inflight_hi);
  assign w_occupancy  = {1'b0, r_count} + {2'b00, w_pending};
  assign w_issue      = ~bus.redirect & (r_faddr[0] | (w_occupancy < 3'd2));
  assign w_capture_lo = r_inflight & ~r_inflight_hi;
  assign w_push       = r_inflight & r_inflight_hi;
  assign w_pop        = (r_count != 2'd0) & bus.instr_ready;
  assign w_new_word   = {bus.ram_q, r_lo_byte};

  assign bus.ram_addr    = r_faddr;
  assign bus.instr_valid = (r_count != 2'd0);
  assign bus.instr       = r_word0;
  assign bus.instr_pc    = r_pc0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_faddr       <= C_RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_hi <= 1'b0;
      r_have_lo     <= 1'b0;
      r_lo_byte     <= 8'h00;
      r_lo_pc       <= '0;
    end else if (bus.redirect) begin
      r_faddr    <= {bus.redirect_pc[ADDR_W-1:1], 1'b0};
      r_inflight <= 1'b0;
      r_have_lo  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_faddr       <= r_faddr + 1'b1;
        r_inflight_hi <= r_faddr[0];
      end
      // The high byte issues on the same edge, so faddr still points at lo+1 here.
      if (w_capture_lo) begin
        r_lo_byte <= bus.ram_q;
        r_lo_pc   <= {r_faddr[ADDR_W-1:1], 1'b0};
        r_have_lo <= 1'b1;
      end else if (w_push) begin
        r_have_lo <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_word0 <= 16'h0000;
      r_word1 <= 16'h0000;
      r_pc0   <= '0;
      r_pc1   <= '0;
    end else if (bus.redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_word0 <= r_word1;
            r_pc0   <= r_pc1;
            r_word1 <= w_new_word;
            r_pc1   <= r_lo_pc;
          end else begin
            r_word0 <= w_new_word;
            r_pc0   <= r_lo_pc;
          end
        end
        2'b10: begin
          r_count <= r_count + 2'd1;
          if (r_count == 2'd0) begin
            r_word0 <= w_new_word;
            r_pc0   <= r_lo_pc;
          end else begin
            r_word1 <= w_new_word;
            r_pc1   <= r_lo_pc;
          end
        end
        2'b01: begin
          r_count <= r_count - 2'd1;
          r_word0 <= r_word1;
          r_pc0   <= r_pc1;
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (!bus.instr_valid && !bus.redirect && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
